// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - md_op_e    : op encodings presented on the op port
//   - md_state_e : sequencer states (idle, iterate, sign fix-up)
//   - step_mode_e: selects the multiply or divide iteration in muldiv_step
//   - WIDTH_DEF  : default operand / HI / LO width
package hilo_muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/hilo_muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the unsigned multiply/divide
// datapath. The 2*WIDTH partial value is {upper half, lower half}.
//   mode        in   STEP_MUL: shift-add, multiplier consumed from the LSB of the
//                    lower half, product accumulates in the upper half.
//                    STEP_DIV: restoring shift-subtract, dividend shifted out of the
//                    top of the lower half, remainder in the upper half.
//   partial     in   2*WIDTH current partial product / remainder+dividend
//   operand     in   WIDTH   multiplicand (mul) or divisor (div), unsigned
//   partial_nxt out  2*WIDTH next partial value; in div mode bit 0 is left clear
//   q_bit       out  1       quotient bit of this step (always 0 in mul mode)
module muldiv_step
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  step_mode_e           mode,
  input  logic [2*WIDTH-1:0]   partial,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   partial_nxt,
  output logic                 q_bit
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;

  always_comb begin
    add_sum     = {1'b0, partial[2*WIDTH-1:WIDTH]} + (partial[0] ? {1'b0, operand} : '0);
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1
    // bits and bit WIDTH of the difference is a clean borrow flag.
    rem_shift   = {partial[2*WIDTH-1:WIDTH], partial[WIDTH-1]};
    rem_diff    = rem_shift - {1'b0, operand};
    partial_nxt = '0;
    q_bit       = 1'b0;
    if (mode == STEP_MUL) begin
      partial_nxt = {add_sum, partial[WIDTH-1:1]};
    end else begin
      q_bit       = ~rem_diff[WIDTH];
      partial_nxt = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     partial[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair.
// Multiply/divide take WIDTH iteration cycles plus one sign fix-up cycle;
// MTHI/MTLO, divide-by-zero and illegal ops complete on the accepting edge.
// Build option: define HILO_MULDIV_DIV_EN to build the divider; otherwise
// DIV/DIVU are answered as illegal ops (done + op_err, HI/LO untouched).
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any operation, clears HI/LO
//   start      in   request, accepted only while busy==0
//   op         in   3-bit op code (md_op_e)
//   operand_a  in   rs: multiplicand / dividend / MTHI-MTLO source
//   operand_b  in   rt: multiplier / divisor
//   busy       out  multi-cycle operation in progress
//   done       out  one-cycle pulse, HI/LO already hold the result
//   op_err     out  one-cycle pulse with done for an illegal/unsupported op
//   hi, lo     out  HI / LO registers
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             op_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    return -v;
  endfunction

  // Magnitude of a value read as two's complement; the most negative value maps
  // onto itself, which is the correct unsigned magnitude 2**(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && (v < 0)) ? negate_w(v) : v;
  endfunction

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step_nxt;
  logic               step_q;
  step_mode_e         step_mode;
  logic [WIDTH-1:0]   opnd;
  logic               neg_res;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  logic mul_op, div_op, sgn_op, mt_hi, mt_lo, bad_op;
  logic a_neg, b_neg, b_zero;
  logic idle_start, run_go;
  logic [WIDTH-1:0] mag_a, mag_b;

`ifdef HILO_MULDIV_DIV_EN
  logic is_div;
  logic neg_rem;
  assign step_mode = is_div ? STEP_DIV : STEP_MUL;
`else
  assign step_mode = STEP_MUL;
`endif

  always_comb begin
    mul_op = 1'b0;
    div_op = 1'b0;
    sgn_op = 1'b0;
    mt_hi  = 1'b0;
    mt_lo  = 1'b0;
    bad_op = 1'b0;
    case (op)
      MD_MULT:  begin mul_op = 1'b1; sgn_op = 1'b1; end
      MD_MULTU: mul_op = 1'b1;
`ifdef HILO_MULDIV_DIV_EN
      MD_DIV:   begin div_op = 1'b1; sgn_op = 1'b1; end
      MD_DIVU:  div_op = 1'b1;
`endif
      MD_MTHI:  mt_hi = 1'b1;
      MD_MTLO:  mt_lo = 1'b1;
      default:  bad_op = 1'b1;
    endcase
  end

  assign a_neg      = operand_a[WIDTH-1];
  assign b_neg      = operand_b[WIDTH-1];
  assign b_zero     = (operand_b == '0);
  assign mag_a      = magnitude(operand_a, sgn_op);
  assign mag_b      = magnitude(operand_b, sgn_op);
  assign idle_start = (state == S_IDLE) && start;
  // Divide by zero never enters the iteration; it is answered at accept.
  assign run_go     = idle_start && (mul_op || (div_op && !b_zero));
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run_go) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST_CNT) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_RUN) ? cnt + CNT_W'(1) : '0;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode        (step_mode),
    .partial     (acc),
    .operand     (opnd),
    .partial_nxt (step_nxt),
    .q_bit       (step_q)
  );

  // ---- accept: latch magnitudes and sign flags / iterate ----
  always_ff @(posedge clock) begin
    if (run_go) begin
      opnd    <= mul_op ? mag_a : mag_b;
      acc     <= {{WIDTH{1'b0}}, (mul_op ? mag_b : mag_a)};
      neg_res <= sgn_op & (a_neg ^ b_neg);
`ifdef HILO_MULDIV_DIV_EN
      is_div  <= div_op;
      neg_rem <= sgn_op & a_neg;
`endif
    end else if (state == S_RUN) begin
      acc <= step_nxt | {{(2*WIDTH-1){1'b0}}, step_q};
    end
  end

  // ---- fix-up: apply result signs ----
  always_comb begin
    {fix_hi, fix_lo} = neg_res ? negate_2w(acc) : acc;
`ifdef HILO_MULDIV_DIV_EN
    if (is_div) begin
      fix_lo = neg_res ? negate_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      fix_hi = neg_rem ? negate_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // ---- architectural HI/LO and completion pulses ----
  always_ff @(posedge clock) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      op_err <= 1'b0;
    end else begin
      done   <= 1'b0;
      op_err <= 1'b0;
      if (state == S_FIX) begin
        hi   <= fix_hi;
        lo   <= fix_lo;
        done <= 1'b1;
      end else if (idle_start) begin
        if (mt_hi) begin
          hi   <= operand_a;
          done <= 1'b1;
        end else if (mt_lo) begin
          lo   <= operand_a;
          done <= 1'b1;
        end else if (div_op && b_zero) begin
          hi   <= operand_a;
          lo   <= '1;
          done <= 1'b1;
        end else if (bad_op) begin
          done   <= 1'b1;
          op_err <= 1'b1;
        end
      end
    end
  end

endmodule
